// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encodings and
// the default line rate / main clock constants used by the UART and the arbiter.
`timescale 1ns/1ps
package uart_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arbState_t;

    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int BAUDRATE     = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1,
// wrapping modulo NREQ, returned both one-hot and as an index.
`timescale 1ns/1ps
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] winner_o,
    output logic [IW-1:0]   winIdx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the ring starting just past the last owner; the first hit wins.
    always_comb begin
        winner_o = '0;
        winIdx_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(ptr_i) + off) % NREQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                winner_o[cand] = 1'b1;
                winIdx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A grant covers a whole packet; a granted requester that stalls is dropped.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [8*NREQ-1:0] REQ_DATA,
    input  logic [NREQ-1:0]   REQ_LAST,
    output logic [NREQ-1:0]   REQ_READY,
    output logic [NREQ-1:0]   GRANT,
    output logic              TXSTART,
    output logic [7:0]        TXDATA,
    input  logic              TXBUSY,
    input  logic              TXDONE,
    output logic              BUSY,
    output logic              TIMEOUT_ERR
);

    localparam int               IW         = $clog2(NREQ);
    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    arbState_t        state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gIdx_q, gIdx_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [7:0]       txData_q, txData_d;
    logic             last_q, last_d;
    logic             txStart_q, txStart_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
    logic [CNT_W-1:0] idleCntInc;

    logic [NREQ-1:0]  pickOneHot;
    logic [IW-1:0]    pickIdx;
    logic             curValid;
    logic             curLast;
    logic [7:0]       curData;
    logic             accept;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (REQ_VALID),
        .ptr_i    (ptr_q),
        .winner_o (pickOneHot),
        .winIdx_o (pickIdx)
    );

    assign curValid   = REQ_VALID[gIdx_q];
    assign curLast    = REQ_LAST[gIdx_q];
    assign curData    = REQ_DATA[{gIdx_q, 3'b000} +: 8];
    assign accept     = (state_q == ST_SEND) && curValid && !TXBUSY;
    assign idleCntInc = (idleCnt_q == '1) ? idleCnt_q : idleCnt_q + 1'b1;

    // Only the owner can be handshaken, and only while the UART is free.
    always_comb begin
        REQ_READY = '0;
        if (state_q == ST_SEND && !TXBUSY) begin
            REQ_READY = grant_q & REQ_VALID;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gIdx_d       = gIdx_q;
        grant_d      = grant_q;
        txData_d     = txData_q;
        last_d       = last_q;
        txStart_d    = 1'b0;
        timeoutErr_d = 1'b0;
        idleCnt_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (|REQ_VALID) begin
                    grant_d = pickOneHot;
                    gIdx_d  = pickIdx;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (accept) begin
                    txData_d  = curData;
                    last_d    = curLast;
                    txStart_d = 1'b1;
                    state_d   = ST_WAIT;
                end else if (!curValid) begin
                    // Saturating count of consecutive empty cycles from the owner.
                    idleCnt_d = idleCntInc;
                    if (TIMEOUT_EN && (idleCntInc >= CNT_LIMIT)) begin
                        timeoutErr_d = 1'b1;
                        ptr_d        = gIdx_q;
                        grant_d      = '0;
                        idleCnt_d    = '0;
                        state_d      = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                if (TXDONE) begin
                    if (last_q) begin
                        ptr_d   = gIdx_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ptr resets to the last index so that requester 0 has first priority.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IW'(NREQ - 1);
            gIdx_q       <= '0;
            grant_q      <= '0;
            txData_q     <= '0;
            last_q       <= 1'b0;
            txStart_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
            idleCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gIdx_q       <= gIdx_d;
            grant_q      <= grant_d;
            txData_q     <= txData_d;
            last_q       <= last_d;
            txStart_q    <= txStart_d;
            timeoutErr_q <= timeoutErr_d;
            idleCnt_q    <= idleCnt_d;
        end
    end

    assign GRANT       = grant_q;
    assign TXSTART     = txStart_q;
    assign TXDATA      = txData_q;
    assign TIMEOUT_ERR = timeoutErr_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a serial UART TX/RX
// loopback model, a packet-level reference model and per-cycle comparison.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int TIMEOUT_P = 16;
    localparam int BITC      = 4;
    localparam int BIT_NS    = BITC * 10;
    localparam int QDEPTH    = 32;

    logic              CLK;
    logic              RESET;
    logic [NREQ-1:0]   reqValid;
    logic [8*NREQ-1:0] reqData;
    logic [NREQ-1:0]   reqLast;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ-1:0]   grant;
    logic              txStart;
    logic [7:0]        txData;
    logic              txBusy;
    logic              uartDone;
    logic              strayDone;
    logic              txDone;
    logic              busy;
    logic              timeoutErr;

    assign txDone = uartDone | strayDone;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT_P)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_VALID   (reqValid),
        .REQ_DATA    (reqData),
        .REQ_LAST    (reqLast),
        .REQ_READY   (reqReady),
        .GRANT       (grant),
        .TXSTART     (txStart),
        .TXDATA      (txData),
        .TXBUSY      (txBusy),
        .TXDONE      (txDone),
        .BUSY        (busy),
        .TIMEOUT_ERR (timeoutErr)
    );

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    int cyc = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester byte queues; a byte leaves its queue when REQ_READY was high at an edge.
    logic [8:0] reqMem [NREQ][QDEPTH];
    int head [NREQ];
    int tail [NREQ];
    logic [NREQ-1:0] popMask;
    bit rstSeen;

    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
        reqMem[idx][tail[idx]] = {last, data};
        tail[idx] = tail[idx] + 1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        forever begin
            @(posedge CLK);
            popMask = reqReady;
            rstSeen = !RESET;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rstSeen) head[i] = tail[i];
                else if (popMask[i]) head[i] = head[i] + 1;
                if (head[i] != tail[i]) begin
                    reqValid[i]        = 1'b1;
                    reqData[i*8 +: 8]  = reqMem[i][head[i]][7:0];
                    reqLast[i]         = reqMem[i][head[i]][8];
                end else begin
                    reqValid[i]        = 1'b0;
                    reqData[i*8 +: 8]  = 8'h00;
                    reqLast[i]         = 1'b0;
                end
            end
        end
    end

    // UART transmitter model: 10-bit frame, BITC cycles per bit, aborts on reset.
    logic       txLine;
    logic [9:0] frame;
    bit         aborted;

    initial begin
        txBusy   = 1'b0;
        uartDone = 1'b0;
        txLine   = 1'b1;
        forever begin
            @(posedge CLK);
            if (RESET && txStart) begin
                frame   = {1'b1, txData, 1'b0};
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    #1;
                    txBusy = 1'b1;
                    txLine = frame[b];
                    for (int c = 0; c < BITC && !aborted; c++) begin
                        @(posedge CLK);
                        if (!RESET) aborted = 1'b1;
                    end
                end
                #1;
                txLine = 1'b1;
                txBusy = 1'b0;
                if (!aborted) begin
                    uartDone = 1'b1;
                    @(posedge CLK);
                    #1;
                    uartDone = 1'b0;
                end
            end
        end
    end

    // UART receiver model on the looped-back line, sampling mid-bit.
    logic [7:0] rxShift;
    logic [7:0] rxData;
    int         rxCount = 0;

    initial begin
        rxData = 8'h00;
        forever begin
            @(negedge txLine);
            #(BIT_NS / 2);
            for (int b = 0; b < 8; b++) begin
                #(BIT_NS);
                rxShift[b] = txLine;
            end
            #(BIT_NS);
            rxData  = rxShift;
            rxCount = rxCount + 1;
        end
    end

    // Reference model: owner index (-1 when idle), and whether a byte is on the line.
    int         mOwner = -1;
    bit         mWaiting = 1'b0;
    bit         mLast = 1'b0;
    int         mIdle = 0;
    int         mPtr = NREQ - 1;
    logic [7:0] mTxData = 8'h00;
    bit         mTxStart = 1'b0;
    bit         mTerr = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            mTxStart = 1'b0;
            mTerr    = 1'b0;
            if (!RESET) begin
                mOwner   = -1;
                mWaiting = 1'b0;
                mLast    = 1'b0;
                mIdle    = 0;
                mPtr     = NREQ - 1;
                mTxData  = 8'h00;
            end else if (mOwner < 0) begin
                for (int off = 1; off <= NREQ; off++) begin
                    if (mOwner < 0 && reqValid[(mPtr + off) % NREQ]) mOwner = (mPtr + off) % NREQ;
                end
            end else if (!mWaiting) begin
                if (reqValid[mOwner] && !txBusy) begin
                    mTxData  = reqData[mOwner*8 +: 8];
                    mLast    = reqLast[mOwner];
                    mTxStart = 1'b1;
                    mWaiting = 1'b1;
                    mIdle    = 0;
                end else if (reqValid[mOwner]) begin
                    mIdle = 0;
                end else begin
                    mIdle = mIdle + 1;
                    if (TIMEOUT_P > 0 && mIdle >= TIMEOUT_P) begin
                        mTerr  = 1'b1;
                        mPtr   = mOwner;
                        mOwner = -1;
                        mIdle  = 0;
                    end
                end
            end else if (txDone) begin
                mWaiting = 1'b0;
                if (mLast) begin
                    mPtr   = mOwner;
                    mOwner = -1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    logic [NREQ-1:0] expGrant;
    logic [NREQ-1:0] expReady;

    initial begin
        forever begin
            @(negedge CLK);
            if (checkEn) begin
                expGrant = '0;
                expReady = '0;
                if (mOwner >= 0) begin
                    expGrant[mOwner] = 1'b1;
                    if (!mWaiting && reqValid[mOwner] && !txBusy) expReady[mOwner] = 1'b1;
                end
                checkOutput("GRANT", grant, expGrant);
                checkOutput("REQ_READY", reqReady, expReady);
                checkOutput("TXSTART", txStart, mTxStart);
                checkOutput("TXDATA", txData, mTxData);
                checkOutput("BUSY", busy, (mOwner >= 0));
                checkOutput("TIMEOUT_ERR", timeoutErr, mTerr);
            end
        end
    end

    // Event log used by the hand-computed expectations.
    logic [NREQ-1:0] startGrant [64];
    logic [7:0]      startData [64];
    int nStart = 0;
    int terrCyc = -1;
    int doneCyc3 = -1;
    logic [NREQ-1:0] grantAtTerr;

    initial begin
        forever begin
            @(negedge CLK);
            if (checkEn && txStart === 1'b1 && nStart < 64) begin
                startGrant[nStart] = grant;
                startData[nStart]  = txData;
                nStart = nStart + 1;
            end
            if (checkEn && timeoutErr === 1'b1) begin
                terrCyc     = cyc;
                grantAtTerr = grant;
            end
            if (uartDone && grant == 4'b1000) doneCyc3 = cyc;
        end
    end

    task automatic waitIdle(input int limit);
        int  n  = 0;
        bit  ok = 1'b0;
        bit  empty;
        while (n < limit && !ok) begin
            @(negedge CLK);
            n++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) empty = 1'b0;
            if (!busy && !txBusy && empty) ok = 1'b1;
        end
        checkOutput("waitIdle", ok, 1);
    endtask

    task automatic waitStarts(input int target, input int limit);
        int n = 0;
        while (nStart < target && n < limit) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("waitStarts", (nStart >= target), 1);
    endtask

    task automatic pulseReset();
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int base;
    int rxBase;
    int n;

    initial begin
        RESET     = 1'b0;
        strayDone = 1'b0;
        @(posedge CLK);
        #1 checkEn = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b1;

        @(negedge CLK);
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstTxStart", txStart, 0);
        checkOutput("rstTxData", txData, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTimeoutErr", timeoutErr, 0);

        // A TXDONE while idle must not wake the arbiter.
        @(posedge CLK);
        #1 strayDone = 1'b1;
        @(posedge CLK);
        #1 strayDone = 1'b0;
        @(negedge CLK);
        checkOutput("strayDoneIdle", busy, 0);

        // Requester 2 sends a three-byte packet.
        base = nStart;
        applyStimulus(2, 8'hA1, 1'b0);
        applyStimulus(2, 8'hA2, 1'b0);
        applyStimulus(2, 8'hA3, 1'b1);
        waitIdle(400);
        checkOutput("t1Count", nStart - base, 3);
        checkOutput("t1Data0", startData[base],     8'hA1);
        checkOutput("t1Data1", startData[base + 1], 8'hA2);
        checkOutput("t1Data2", startData[base + 2], 8'hA3);
        for (int k = 0; k < 3; k++) checkOutput("t1Grant", startGrant[base + k], 4'b0100);
        checkOutput("t1GrantEnd", grant, 0);

        // All four request together right after reset: order 0,1,2,3.
        pulseReset();
        @(negedge CLK);
        base = nStart;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'h10 + 8'(i), 1'b1);
        waitIdle(800);
        checkOutput("t2Count", nStart - base, 4);
        checkOutput("t2Order0", startGrant[base],     4'b0001);
        checkOutput("t2Order1", startGrant[base + 1], 4'b0010);
        checkOutput("t2Order2", startGrant[base + 2], 4'b0100);
        checkOutput("t2Order3", startGrant[base + 3], 4'b1000);
        // Pointer now sits on 3, so 0 beats 3.
        base = nStart;
        applyStimulus(3, 8'h33, 1'b1);
        applyStimulus(0, 8'h00, 1'b1);
        waitIdle(400);
        checkOutput("t2PtrA", startGrant[base],     4'b0001);
        checkOutput("t2PtrB", startGrant[base + 1], 4'b1000);

        // Requester 0 arrives while requester 1 is mid-packet.
        base = nStart;
        applyStimulus(1, 8'hB1, 1'b0);
        applyStimulus(1, 8'hB2, 1'b1);
        waitStarts(base + 1, 100);
        applyStimulus(0, 8'hC0, 1'b1);
        waitIdle(400);
        checkOutput("t3Grant0", startGrant[base],     4'b0010);
        checkOutput("t3Grant1", startGrant[base + 1], 4'b0010);
        checkOutput("t3Grant2", startGrant[base + 2], 4'b0001);
        checkOutput("t3Data2",  startData[base + 2],  8'hC0);

        // Requester 3 stalls after a non-last byte and is revoked by timeout.
        base     = nStart;
        doneCyc3 = -1;
        terrCyc  = -1;
        applyStimulus(3, 8'h3C, 1'b0);
        waitStarts(base + 1, 100);
        applyStimulus(0, 8'h0D, 1'b1);
        n = 0;
        while (doneCyc3 < 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t4DoneSeen", (doneCyc3 >= 0), 1);
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1 strayDone = 1'b1;
        @(posedge CLK);
        #1 strayDone = 1'b0;
        waitIdle(400);
        checkOutput("t4TimeoutDelay", terrCyc - doneCyc3, 17);
        checkOutput("t4GrantAtTerr", grantAtTerr, 0);
        checkOutput("t4NextGrant", startGrant[base + 1], 4'b0001);
        checkOutput("t4NextData",  startData[base + 1],  8'h0D);

        // Reset while waiting on requester 1's second byte.
        base = nStart;
        applyStimulus(1, 8'h51, 1'b0);
        applyStimulus(1, 8'h52, 1'b0);
        applyStimulus(1, 8'h53, 1'b1);
        waitStarts(base + 2, 200);
        repeat (6) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        checkOutput("t5Grant", grant, 0);
        checkOutput("t5Ready", reqReady, 0);
        checkOutput("t5TxStart", txStart, 0);
        checkOutput("t5TxData", txData, 0);
        checkOutput("t5Busy", busy, 0);
        checkOutput("t5TimeoutErr", timeoutErr, 0);
        base = nStart;
        applyStimulus(1, 8'h61, 1'b1);
        applyStimulus(0, 8'h60, 1'b1);
        waitIdle(400);
        checkOutput("t5First",  startGrant[base],     4'b0001);
        checkOutput("t5Second", startGrant[base + 1], 4'b0010);

        // Loopback: 8'hEE from requester 0 arrives intact at the receiver.
        repeat (60) @(negedge CLK);
        rxBase = rxCount;
        applyStimulus(0, 8'hEE, 1'b1);
        n = 0;
        while (!uartDone && n < 400) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t6DoneSeen", uartDone, 1);
        checkOutput("t6BusyAtDone", busy, 1);
        @(negedge CLK);
        checkOutput("t6BusyAfterDone", busy, 0);
        checkOutput("t6RxCount", rxCount - rxBase, 1);
        checkOutput("t6RxData", rxData, 8'hEE);

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `UART` transmitter among `NREQ` byte-stream requesters. It sits between the requesters and the `UART` TX port (`TXSTART`/`TXDATA`/`TXBUSY`/`TXDONE`). A grant is held for a whole packet, delimited by `REQ_LAST`, so bytes from different requesters never interleave on the line. A stalled packet is released after a programmable idle timeout.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: cycles a granted requester may leave `REQ_VALID` low mid-packet before the grant is revoked; 0 disables the timeout.

Ports:
- `CLK`  in  1  single system clock.
- `RESET`  in  1  synchronous, active-low reset.
- `REQ_VALID`  in  NREQ  requester i has a byte ready.
- `REQ_DATA`  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- `REQ_LAST`  in  NREQ  byte on requester i is the last byte of its packet.
- `REQ_READY`  out  NREQ  byte of requester i accepted this cycle.
- `GRANT`  out  NREQ  one-hot owner of the transmitter; all zero when idle.
- `TXSTART`  out  1  one-cycle start pulse to `UART`.
- `TXDATA`  out  8  byte to `UART`, held stable until the next accept.
- `TXBUSY`  in  1  `UART` transmitter busy.
- `TXDONE`  in  1  one-cycle pulse when the `UART` stop bit completes.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `TIMEOUT_ERR`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- State machine has three states: IDLE, SEND and WAIT.
- IDLE:
  - If any `REQ_VALID` is high, the block picks the first requester at or after `ptr+1`, wrapping modulo `NREQ`.
  - It sets `GRANT` one-hot to that requester and goes to SEND.
- SEND:
  - `REQ_READY[g] = REQ_VALID[g] & !TXBUSY` for the granted index g. `REQ_READY` is combinational and is zero for all other indices.
  - On an accept, the byte is registered into `TXDATA`, `REQ_LAST[g]` is latched into `last_q`, `TXSTART` pulses on the next cycle, and the state goes to WAIT.
  - While `REQ_VALID[g]` is low, `idle_cnt` increments. It clears on any cycle `REQ_VALID[g]` is high.
  - If `idle_cnt` reaches `TIMEOUT` and `TIMEOUT` is nonzero:
    - pulse `TIMEOUT_ERR`;
    - set `ptr` to g;
    - clear `GRANT`;
    - go to IDLE.
- WAIT:
  - On `TXDONE`: if `last_q` is set, `ptr` becomes g, `GRANT` clears and the state goes to IDLE; otherwise the state returns to SEND.
- `REQ_VALID` changes on non-granted requesters are ignored until the next arbitration.
- Reset values (the `UART` shares the same `RESET`):
  - state IDLE;
  - `ptr` = `NREQ`-1, so requester 0 has first priority;
  - `GRANT`, `REQ_READY`, `TXSTART`, `TXDATA`, `BUSY`, `TIMEOUT_ERR` all 0;
  - `idle_cnt` 0, `last_q` 0.
- Reset mid-packet abandons the packet. No byte is replayed.

## Timing
- A valid request sampled in IDLE at edge k gives `GRANT` and SEND from k+1. The earliest accept is at edge k+1, with `TXSTART` high from k+1 to k+2.
- The first byte therefore reaches `TXSTART` 2 cycles after `REQ_VALID` rises while the block is idle.
- `TXSTART` is high for exactly one cycle per accepted byte. `TXDATA` changes only on accept.
- Back-to-back bytes in one packet: the next accept happens in the cycle after `TXDONE`, provided `REQ_VALID` is high and `TXBUSY` is low.
- `TXDONE` and `REQ_VALID` from another requester in the same cycle: the packet ends first. The new arbitration happens in IDLE on the following cycle (1 bubble).
- Timeout check: `idle_cnt` width is clog2(`TIMEOUT`+1). The compare is `>=` and the counter saturates.
- `TXDONE` seen outside WAIT is ignored.

## Structure
- Shared package/header `uart_defs`:
  - state encodings `ST_IDLE`=2'd0, `ST_SEND`=2'd1, `ST_WAIT`=2'd2;
  - the default `BAUDRATE` and main-clock constants used by both the `UART` and this block.
- Sub-module `uart_rr_pick`: purely combinational. Inputs are the `NREQ`-bit request vector and `ptr`. Outputs are the one-hot winner and its index. It is instantiated once.

## Test plan
- Reset, then requester 2 sends 3 bytes 8'hA1, 8'hA2, 8'hA3 with `REQ_LAST` on the third:
  - `GRANT`=4'b0100 throughout;
  - three `TXSTART` pulses in order, each after the previous `TXDONE`;
  - `GRANT` is 0 after the final `TXDONE`.
- All four requesters request simultaneously with 1-byte packets: grant order is 0, 1, 2, 3, and `ptr` ends at 3.
- Requester 1 is mid-packet and requester 0 asserts valid: requester 0 gets no `REQ_READY` until after requester 1's `REQ_LAST` byte completes.
- Requester 3 is granted, sends 1 non-last byte, then drops valid, with `TIMEOUT`=16:
  - `TIMEOUT_ERR` pulses 16 cycles after WAIT returns to SEND;
  - `GRANT` clears;
  - requester 0 is served next.
- `RESET` is driven low while in WAIT for requester 1's second byte: the next cycle shows all outputs 0 and state IDLE, and a following request from 0 is granted first.
- Loopback TX to RX, send 8'hEE from requester 0: `RXDATA`=8'hEE at `RXDONE`, and `BUSY` falls the cycle after `TXDONE`.
